// File: rtl/batch_fifo_transmitter.sv
// batch_fifo_transmitter
//   Store-and-forward sender. Words are buffered in a DEPTH-entry FIFO and handed
//   one at a time to a downstream transmitter through a start/busy handshake.
//   Stream mode (mode=0) sends whenever data is queued. Batch mode (mode=1) holds
//   words until BATCH_SIZE are queued or flush is pulsed, then drains the whole queue.
//
//   Handshake: the downstream side owns tx_busy. A new word is only loaded while
//   tx_busy is low. tx_start is a single-cycle pulse during which tx_data is valid.
//   tx_data then holds its value until the next word is loaded. One GAP cycle after
//   each pulse gives the transmitter time to raise tx_busy.
//
// Ports
//   CLOCK_50   in   clock, rising edge
//   reset      in   asynchronous, active-high
//   wr_en      in   push wr_data this cycle (dropped when full)
//   wr_data    in   word to enqueue
//   mode       in   0 = stream, 1 = batch (sampled in IDLE)
//   flush      in   batch mode: start a drain regardless of level
//   tx_busy    in   downstream transmitter busy
//   tx_start   out  1-cycle pulse, tx_data valid
//   tx_data    out  registered word being sent
//   full       out  level == DEPTH
//   empty      out  level == 0
//   level      out  number of words stored
//   overflow   out  sticky: a write was dropped while full
//   active     out  FSM not in IDLE
//   fsm_state  out  current FSM state, for observation

module batch_fifo_transmitter #(
   parameter int WORD_SIZE  = 4,
   parameter int DEPTH      = 8,
   parameter int BATCH_SIZE = 4
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [WORD_SIZE-1:0]         wr_data,
   input  logic                         mode,
   input  logic                         flush,
   input  logic                         tx_busy,
   output logic                         tx_start,
   output logic [WORD_SIZE-1:0]         tx_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   output logic                         active,
   output logic [1:0]                   fsm_state
);

   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] LOAD     = 2'd1;
   localparam logic [1:0] TRANSMIT = 2'd2;
   localparam logic [1:0] GAP      = 2'd3;

   logic [WORD_SIZE-1:0] mem_q [DEPTH];
   logic [WORD_SIZE-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 overflow_q, overflow_d;
   logic                 drain_q, drain_d;
   logic [1:0]           state_q, state_d;
   logic [WORD_SIZE-1:0] tx_data_q, tx_data_d;

   logic full_w, empty_w, wr_acc, rd_acc, go;

   always_comb begin
      full_w  = (level_q == LVL_W'(DEPTH));
      empty_w = (level_q == '0);
      wr_acc  = wr_en && !full_w;
      // LOAD is only entered with data present; the empty guard keeps the
      // pointers safe regardless.
      rd_acc  = (state_q == LOAD) && !empty_w;
      go      = !empty_w && (!mode || drain_q);

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drain_d    = drain_q;
      state_d    = state_q;
      tx_data_d  = tx_data_q;

      if (wr_acc) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (wr_en && full_w) begin
         overflow_d = 1'b1;
      end
      if (rd_acc) begin
         tx_data_d = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end

      // Simultaneous write and read leaves the level unchanged.
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // Setting wins over the IDLE/empty clear so a flush into an empty queue
      // arms the drain for the next word.
      if (!mode) begin
         drain_d = 1'b0;
      end else if ((level_q >= LVL_W'(BATCH_SIZE)) || flush) begin
         drain_d = 1'b1;
      end else if ((state_q == IDLE) && empty_w) begin
         drain_d = 1'b0;
      end

      case (state_q)
         IDLE:     if (go && !tx_busy) state_d = LOAD;
         LOAD:     state_d = TRANSMIT;
         TRANSMIT: state_d = GAP;
         GAP:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drain_q    <= 1'b0;
         state_q    <= IDLE;
         tx_data_q  <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drain_q    <= drain_d;
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // tx_start decodes the registered state, so an async reset drops it at once.
   assign tx_start  = (state_q == TRANSMIT);
   assign tx_data   = tx_data_q;
   assign full      = full_w;
   assign empty     = empty_w;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign active    = (state_q != IDLE);
   assign fsm_state = state_q;

endmodule

// File: tb/tb_batch_fifo_transmitter.sv
module tb_batch_fifo_transmitter;

   localparam int W = 4;

   logic         CLOCK_50;
   logic         reset;
   logic         wr_en;
   logic [W-1:0] wr_data;
   logic         mode;
   logic         flush;
   logic         tx_busy;
   logic         tx_start;
   logic [W-1:0] tx_data;
   logic         full;
   logic         empty;
   logic [3:0]   level;
   logic         overflow;
   logic         active;
   logic [1:0]   fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tx_count = 0;

   logic [W-1:0] exp_q[$];
   int           tx_times[$];

   batch_fifo_transmitter #(.WORD_SIZE(4), .DEPTH(8), .BATCH_SIZE(4)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .mode(mode), .flush(flush), .tx_busy(tx_busy), .tx_start(tx_start),
      .tx_data(tx_data), .full(full), .empty(empty), .level(level),
      .overflow(overflow), .active(active), .fsm_state(fsm_state)
   );

   // clock / reset
   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // scoreboard: every tx_start pops the oldest expected word
   always @(negedge CLOCK_50) begin
      if (!reset && tx_start) begin
         tx_count = tx_count + 1;
         tx_times.push_back(cyc);
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sb_unexpected_tx got=%0h expected=none", tx_data);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               errors = errors + 1;
               $display("FAIL sb_tx_data got=%0h expected=%0h", tx_data, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic push(input logic [W-1:0] d, input bit will_send);
      @(posedge CLOCK_50); #1;
      wr_en = 1'b1; wr_data = d;
      if (will_send) exp_q.push_back(d);
      @(posedge CLOCK_50); #1;
      wr_en = 1'b0;
   endtask

   task automatic pulse_flush();
      @(posedge CLOCK_50); #1;
      flush = 1'b1;
      @(posedge CLOCK_50); #1;
      flush = 1'b0;
   endtask

   task automatic wait_tx(input int target, input int budget, input string name);
      int b;
      b = budget;
      while (tx_count < target && b > 0) begin
         @(posedge CLOCK_50); b--;
      end
      #1;
      checks = checks + 1;
      if (tx_count < target) begin
         errors = errors + 1;
         $display("FAIL %s_timeout got=%0d expected=%0d", name, tx_count, target);
      end
   endtask

   task automatic do_reset();
      @(posedge CLOCK_50); #1;
      reset = 1'b1;
      exp_q.delete();
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   // tests
   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      checks++;
      if ({tx_start, tx_data, level, empty, full, overflow, active} !== {1'b0, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got=%b expected=%b",
                  {tx_start, tx_data, level, empty, full, overflow, active}, 15'b0_0000_0000_1_0_0_0);
      end
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_stream_latency();
      int base;
      base = tx_count;
      mode = 1'b0; tx_busy = 1'b0;
      @(posedge CLOCK_50); #1;
      wr_en = 1'b1; wr_data = 4'h3;   // cycle k
      exp_q.push_back(4'h3);
      @(posedge CLOCK_50); #1;        // cycle k+1
      wr_en = 1'b0;
      checks++;
      if (level !== 4'd1) begin errors++; $display("FAIL lat_level1 got=%0d expected=1", level); end
      @(posedge CLOCK_50); #1;        // cycle k+2
      checks++;
      if (tx_start !== 1'b0) begin errors++; $display("FAIL lat_early got=%b expected=0", tx_start); end
      @(posedge CLOCK_50); #1;        // cycle k+3
      checks++;
      if (tx_start !== 1'b1 || tx_data !== 4'h3) begin
         errors++;
         $display("FAIL lat_k3 got=%b/%0h expected=1/3", tx_start, tx_data);
      end
      checks++;
      if (level !== 4'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL lat_level0 got=%0d/%b expected=0/1", level, empty);
      end
      tick(4);
      checks++;
      if (tx_count != base + 1) begin errors++; $display("FAIL lat_count got=%0d expected=%0d", tx_count, base + 1); end
   endtask

   task automatic test_busy_hold();
      int base;
      base = tx_count;
      mode = 1'b0; tx_busy = 1'b1;
      push(4'h1, 1'b1); push(4'h2, 1'b1); push(4'h3, 1'b1);
      tick(10);
      checks++;
      if (tx_count != base || level !== 4'd3) begin
         errors++;
         $display("FAIL busy_hold got=%0d/%0d expected=%0d/3", tx_count, level, base);
      end
      tx_times.delete();
      tx_busy = 1'b0;
      wait_tx(base + 3, 40, "busy_release");
      checks++;
      if (tx_times.size() == 3 && (tx_times[1] - tx_times[0] != 4 || tx_times[2] - tx_times[1] != 4)) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d,%0d expected=4,4", tx_times[1] - tx_times[0], tx_times[2] - tx_times[1]);
      end else if (tx_times.size() != 3) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d pulses expected=3", tx_times.size());
      end
   endtask

   task automatic test_batch_level();
      int base;
      base = tx_count;
      mode = 1'b1; tx_busy = 1'b0;
      push(4'hA, 1'b1); push(4'hB, 1'b1); push(4'hC, 1'b1);
      tick(10);
      checks++;
      if (tx_count != base || level !== 4'd3) begin
         errors++;
         $display("FAIL batch_wait got=%0d/%0d expected=%0d/3", tx_count, level, base);
      end
      push(4'hD, 1'b1);
      wait_tx(base + 4, 40, "batch_drain");
      tick(3);
      checks++;
      if (empty !== 1'b1 || active !== 1'b0) begin
         errors++;
         $display("FAIL batch_empty got=%b/%b expected=1/0", empty, active);
      end
   endtask

   task automatic test_flush();
      int base;
      base = tx_count;
      mode = 1'b1; tx_busy = 1'b0;
      push(4'h5, 1'b1); push(4'h6, 1'b1);
      tick(8);
      checks++;
      if (tx_count != base) begin errors++; $display("FAIL flush_wait got=%0d expected=%0d", tx_count, base); end
      pulse_flush();
      wait_tx(base + 2, 30, "flush_drain");
      tick(4);
      push(4'h7, 1'b1);
      tick(10);
      checks++;
      if (tx_count != base + 2 || level !== 4'd1) begin
         errors++;
         $display("FAIL drain_cleared got=%0d/%0d expected=%0d/1", tx_count, level, base + 2);
      end
      pulse_flush();
      wait_tx(base + 3, 20, "flush_single");
      tick(4);
   endtask

   task automatic test_overflow();
      int base;
      base = tx_count;
      mode = 1'b0; tx_busy = 1'b1;
      for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 1'b1);
      tick(1);
      checks++;
      if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fill got=%b/%0d/%b expected=1/8/0", full, level, overflow);
      end
      push(4'hF, 1'b0);
      tick(1);
      checks++;
      if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow got=%b/%0d/%b expected=1/8/1", full, level, overflow);
      end
      tx_busy = 1'b0;
      wait_tx(base + 8, 80, "overflow_drain");
      tick(10);
      checks++;
      if (tx_count != base + 8 || empty !== 1'b1 || exp_q.size() != 0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_drain got=%0d/%b/%0d/%b expected=%0d/1/0/1",
                  tx_count, empty, exp_q.size(), overflow, base + 8);
      end
   endtask

   task automatic test_reset_mid_send();
      int base, b;
      mode = 1'b0; tx_busy = 1'b1;
      for (int i = 0; i < 6; i++) push(4'($urandom_range(0, 15)), 1'b1);
      tx_busy = 1'b0;
      b = 20;
      while (tx_start !== 1'b1 && b > 0) begin
         @(posedge CLOCK_50); #1; b--;
      end
      checks++;
      if (tx_start !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_reach got=%b expected=1", tx_start);
      end
      checks++;
      if (level !== 4'd5) begin errors++; $display("FAIL rst_mid_queued got=%0d expected=5", level); end
      reset = 1'b1;
      exp_q.delete();
      #1;
      checks++;
      if ({tx_start, level, empty, active} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rst_mid_async got=%b expected=%b", {tx_start, level, empty, active}, 7'b0_0000_1_0);
      end
      tick(2);
      reset = 1'b0;
      base = tx_count;
      tick(20);
      checks++;
      if (tx_count != base || tx_data !== 4'h0) begin
         errors++;
         $display("FAIL rst_mid_quiet got=%0d/%0h expected=%0d/0", tx_count, tx_data, base);
      end
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_data = '0; mode = 1'b0; flush = 1'b0; tx_busy = 1'b0;
      test_reset();
      test_stream_latency();
      test_busy_hold();
      test_batch_level();
      test_flush();
      test_overflow();
      test_reset_mid_send();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
